// File: rtl/surf_simplified_sdiv_seq.sv
// Sequential signed-by-unsigned restoring divider, one quotient bit per clock,
// truncating toward zero, with an ap_start/ap_done/ap_idle/ap_ready handshake.
module surf_simplified_sdiv_seq #(
  parameter int DIVIDEND_WIDTH = 16,
  parameter int DIVISOR_WIDTH  = 11
) (
  input  logic                             ap_clk,
  input  logic                             ap_rst_n,
  input  logic                             ap_start,
  input  logic signed [DIVIDEND_WIDTH-1:0] dividend,
  input  logic        [DIVISOR_WIDTH-1:0]  divisor,
  output logic                             ap_idle,
  output logic                             ap_ready,
  output logic                             ap_done,
  output logic signed [DIVIDEND_WIDTH-1:0] quotient,
  output logic signed [DIVISOR_WIDTH:0]    remainder,
  output logic                             div_by_zero
);

  localparam int DW = DIVIDEND_WIDTH;
  localparam int VW = DIVISOR_WIDTH;
  localparam int CW = $clog2(DW);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t          state_q, state_d;
  logic            sgn_q, sgn_d;
  logic [DW-1:0]   mag_q, mag_d;
  logic [VW-1:0]   dvs_q, dvs_d;
  logic [VW-1:0]   r_q, r_d;
  logic [DW-2:0]   qb_q, qb_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   quo_q, quo_d;
  logic [VW:0]     rem_q, rem_d;
  logic            dbz_q, dbz_d;

  logic [DW-1:0]   mag_in;
  logic [VW:0]     rs, rn;
  logic            ge;
  logic [DW-1:0]   qn;

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q <= S_IDLE;
      sgn_q   <= 1'b0;
      mag_q   <= '0;
      dvs_q   <= '0;
      r_q     <= '0;
      qb_q    <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sgn_q   <= sgn_d;
      mag_q   <= mag_d;
      dvs_q   <= dvs_d;
      r_q     <= r_d;
      qb_q    <= qb_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sgn_d   = sgn_q;
    mag_d   = mag_q;
    dvs_d   = dvs_q;
    r_d     = r_q;
    qb_d    = qb_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;

    // -32768 maps to 0x8000, which is exact as an unsigned magnitude.
    mag_in = dividend[DW-1] ? (DW'(0) - dividend) : dividend;

    // Partial remainder is always < divisor, so its top bit can be dropped before the shift.
    rs = {r_q, mag_q[DW-1]};
    ge = (rs >= {1'b0, dvs_q});
    rn = ge ? (rs - {1'b0, dvs_q}) : rs;
    qn = {qb_q, ge};

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (ap_start) begin
          sgn_d = dividend[DW-1];
          mag_d = mag_in;
          dvs_d = divisor;
          r_d   = '0;
          qb_d  = '0;
          cnt_d = '0;
          if (divisor == '0) begin
            state_d = S_DONE;
            quo_d   = dividend[DW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
            rem_d   = dividend[VW:0];
            dbz_d   = 1'b1;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        mag_d = {mag_q[DW-2:0], 1'b0};
        r_d   = rn[VW-1:0];
        qb_d  = qn[DW-2:0];
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(DW-1)) begin
          state_d = S_DONE;
          quo_d   = sgn_q ? (DW'(0) - qn) : qn;
          rem_d   = sgn_q ? ((VW+1)'(0) - rn) : rn;
          dbz_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ap_idle     = (state_q != S_CALC);
  assign ap_ready    = ap_idle;
  assign ap_done     = (state_q == S_DONE);
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: doc/surf_simplified_sdiv_seq.md
Name: surf_simplified_sdiv_seq

Overview:
- Iterative signed-by-unsigned divider. It is the inverse of the pipeline's signed 16-bit × unsigned 11-bit scaling multiplier.
- Used to normalise Hessian/box-filter responses back by filter area, e.g. response / (w*h).
- Produces a signed quotient and remainder, truncating toward zero, one quotient bit per clock.
- Uses an ap_start/ap_done/ap_idle/ap_ready handshake so HLS-generated callers can drive it directly.

Parameters:
- DIVIDEND_WIDTH, 16, signed dividend width (two's complement).
- DIVISOR_WIDTH, 11, unsigned divisor width.
- Fixed relation: quotient width = DIVIDEND_WIDTH; remainder width = DIVISOR_WIDTH+1 (signed).

Ports:
- ap_clk  in  1  sole clock, rising edge.
- ap_rst_n  in  1  reset, synchronous, active-low.
- ap_start  in  1  request; sampled only while ap_idle=1.
- dividend  in  DIVIDEND_WIDTH  signed dividend; captured on accept.
- divisor  in  DIVISOR_WIDTH  unsigned divisor; captured on accept.
- ap_idle  out  1  block is in IDLE or DONE and able to accept.
- ap_ready  out  1  equals ap_idle (inputs consumed on accept cycle).
- ap_done  out  1  one-cycle pulse when results become valid.
- quotient  out  DIVIDEND_WIDTH  signed quotient; held until the next ap_done.
- remainder  out  DIVISOR_WIDTH+1  signed remainder; sign equals dividend sign; held.
- div_by_zero  out  1  set with ap_done when divisor==0; held with the results.

Behaviour:
- Reset (ap_rst_n=0 at a clock edge):
  - state=IDLE, all outputs 0 except ap_idle=ap_ready=1.
  - Applies immediately, even mid-CALC. The in-flight operation is discarded and no ap_done is generated.
- States: IDLE, CALC, DONE.
  - ap_idle=1 in IDLE and DONE; 0 in CALC.
- Accept:
  - Occurs on a rising edge with ap_start=1 and ap_idle=1.
  - Captures sgn=dividend[MSB], mag=|dividend| as an unsigned DIVIDEND_WIDTH value (-32768 -> 32768 fits), and the divisor.
  - Clears the bit counter.
- Divisor==0 on accept:
  - Go to DONE next cycle with no CALC.
  - quotient = sgn ? most-negative (0x8000) : most-positive (0x7FFF).
  - remainder = dividend truncated to DIVISOR_WIDTH+1 bits.
  - div_by_zero=1.
- Otherwise, CALC runs for DIVIDEND_WIDTH cycles using restoring division, MSB first:
  - partial rem r (DIVISOR_WIDTH+1 bits unsigned) = {r, next mag bit}.
  - If r >= divisor: r -= divisor and the quotient bit is 1; otherwise the bit is 0.
  - After the last bit: quotient = sgn ? -q : q; remainder = sgn ? -r : r; div_by_zero=0.
- Latency and ap_done:
  - ap_done=1 for exactly one cycle, on the first cycle of DONE.
  - Normal op: accept at edge N, ap_done high in cycle N+DIVIDEND_WIDTH+1 (17 for defaults).
  - Divisor==0: ap_done high in cycle N+1.
- Outputs:
  - Registered, updated only on the cycle that ap_done rises.
  - Stable otherwise, including while the next operation is in CALC.
- DONE -> IDLE after one cycle.
  - ap_start=1 in DONE is accepted (back-to-back), so DONE transitions straight into CALC.
  - Back-to-back throughput is one result per DIVIDEND_WIDTH+1 cycles.
- ap_start while in CALC is ignored. The inputs are not captured and no error is flagged.
- Identities that must hold for every non-zero divisor:
  - |remainder| < divisor.
  - remainder is zero or has the sign of the dividend.
  - quotient*divisor + remainder == dividend, exactly in 28-bit arithmetic.
- Quotient overflow is impossible for an unsigned divisor ≥1: |q| ≤ 32768 and the -32768 result is representable.

Test Plan:
- dividend=1000, divisor=7 -> quotient=142, remainder=6, div_by_zero=0; ap_done pulses exactly 17 cycles after accept, single cycle wide.
- dividend=-1000, divisor=7 -> quotient=-142, remainder=-6; dividend=-32768, divisor=1 -> quotient=-32768, remainder=0; dividend=32767, divisor=2047 -> quotient=16, remainder=15.
- dividend=5, divisor=0 -> quotient=0x7FFF, remainder=5, div_by_zero=1, ap_done 1 cycle after accept. dividend=-5, divisor=0 -> quotient=0x8000, remainder=-5.
- Start 100/3, then pulse ap_start with 9/9 at cycles 3 and 10 -> both ignored. Result quotient=33, remainder=1. Then back-to-back: ap_start held in DONE with 9/9 -> accepted, next ap_done 17 cycles later gives quotient=1, remainder=0.
- Assert ap_rst_n=0 at cycle 8 of CALC -> no ap_done, outputs=0, ap_idle=1 next cycle. A new 50/5 run then gives quotient=10, remainder=0.
- Randomised 10k operands checked against the identities above against a reference model. Cover divisor ∈ {0,1,2047}, dividend ∈ {-32768,-1,0,32767}.
